debug_display_ctrl: RTL
=======================

Name: debug_display_ctrl

Overview:
- Parametrised board-display front end for the p18240 top level.
- Replaces the fixed four-way switch mux with an N-channel selector. Supported modes: manual select, auto-cycle, single-step and freeze/snapshot.
- Drives two WIDTH-bit display words plus a digit-enable mask into SevenSegmentControl.
- Channels are packed in pairs: pair p shows ch[2p+1] on disp1 and ch[2p] on disp0.

Parameters:
- WIDTH, 16: bits per channel; must be a multiple of 4. DIGITS = WIDTH/4 per word.
- NUM_CH, 8: channel count; even, at least 2. NUM_PAIRS = NUM_CH/2. PW = max(1, clog2(NUM_PAIRS)).
- DWELL, 50000000: cycles per pair in AUTO mode; at least 1.
- BLINK, 25000000: half-period of the FREEZE blink, in cycles; at least 1.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_L  input  1  reset; asynchronous, active-low.
- chData  input  NUM_CH*WIDTH  flattened channels; ch[i] = chData[i*WIDTH +: WIDTH].
- mode  input  2  00 MANUAL, 01 AUTO, 10 STEP, 11 FREEZE.
- sel  input  PW  requested pair in MANUAL and FREEZE.
- step  input  1  synchronous, debounced level; its rising edge advances the pair in STEP mode.
- disp1  output  WIDTH  upper display word (registered).
- disp0  output  WIDTH  lower display word (registered).
- pairIdx  output  PW  pair currently displayed (registered).
- turnOn  output  2*DIGITS  digit enables (registered).
- frozen  output  1  high while FREEZE is active (registered).

Behaviour:
- Reset (asynchronous assert, synchronous release): pairIdx=0, disp1=disp0=0, turnOn all ones, frozen=0, curMode=MANUAL, dwell and blink counters=0, snapshot=0, stepPrev=0.
- mode is sampled every cycle into curMode. Each state below is a value of curMode; the value sampled at edge k governs the update at edge k+1.
- Mode-change rules:
  - A change of mode clears the dwell and blink counters.
  - pairIdx is retained on change.
  - turnOn returns to all ones on leaving FREEZE.
- MANUAL: pairIdx <= min(sel, NUM_PAIRS-1).
- AUTO:
  - The dwell counter counts 0..DWELL-1.
  - When it reaches DWELL-1 it resets to 0 and pairIdx increments, wrapping from NUM_PAIRS-1 to 0.
  - With DWELL=1, the pair advances every cycle.
- STEP:
  - stepPrev <= step on every cycle, in all modes.
  - In STEP, step & ~stepPrev increments pairIdx, with the same wrap as AUTO.
  - Edges seen in other modes are discarded, so a held step on entering STEP does not advance the pair.
- FREEZE:
  - On the first cycle in FREEZE (curMode != FREEZE, mode == FREEZE), all of chData is captured into snapshot. frozen <= 1.
  - pairIdx follows clamped sel.
  - Display words come from snapshot, not live chData.
  - The blink counter counts 0..BLINK-1; at BLINK-1, turnOn inverts (all ones <-> all zeros).
- Data path: disp1/disp0 <= source[2*pairIdx_next+1] / source[2*pairIdx_next], where source is snapshot in FREEZE and chData otherwise.
  - Registered outputs show the new pair and its data at the same edge; latency from any input change to the outputs is one cycle.
- Simultaneous events:
  - A mode change and a step edge in the same cycle: the mode change wins and there is no advance.
  - Reset mid-count aborts everything to reset values.
- sel outside the pair range is clamped to NUM_PAIRS-1 and never indexes out of bounds.

Test Plan:
Parameters for all scenarios: NUM_CH=8, WIDTH=16, DWELL=4, BLINK=3; ch[i]=16'h1000*i+i.
- Reset: assert reset_L=0 mid-AUTO -> same cycle disp1=disp0=0, pairIdx=0, turnOn=8'hFF, frozen=0.
- MANUAL sel=2 -> next cycle disp1=16'h5005, disp0=16'h4004. sel=3 (valid) then clamp check at NUM_CH=6, sel=3 -> pairIdx=2.
- AUTO from pair 0 -> pairIdx steps 1,2,3,0 every 4 cycles. disp0 tracks ch[2p]. Wrap 3->0 shows disp0=16'h0000, disp1=16'h1001.
- STEP with step held high on entry -> no advance. Then three 0->1 pulses -> pairIdx 1,2,3. A pulse in the same cycle as a mode change to MANUAL -> no advance.
- FREEZE at pair 1, then change ch[2] to 16'hBEEF -> disp0 stays 16'h2002, frozen=1, turnOn toggles FF/00 every 3 cycles. Return to MANUAL -> disp0=16'hBEEF, turnOn=8'hFF next cycle.
- DWELL=1 variant -> pairIdx advances every cycle, 0,1,2,3,0.

Source files
------------

// File: rtl/debug_display_ctrl.sv
// -----------------------------------------------------------------------------
// debug_display_ctrl
//
// Board-display front end: picks one pair of debug channels and presents them
// as two display words plus a digit-enable mask for the seven-segment driver.
// Pair p shows ch[2p+1] on disp1 and ch[2p] on disp0.
//
// Modes (mode input, sampled every cycle into cur_mode_q):
//   00 MANUAL : pair follows sel (clamped to the last pair)
//   01 AUTO   : pair advances every DWELL cycles, wrapping to 0
//   10 STEP   : pair advances on each rising edge of step
//   11 FREEZE : all channels captured on entry; display shows the capture,
//               pair follows sel, digit enables blink every BLINK cycles
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_L  in   asynchronous active-low reset
//   chData   in   NUM_CH*WIDTH flattened channels, ch[i] = chData[i*WIDTH +: WIDTH]
//   mode     in   2-bit mode select
//   sel      in   PW-bit requested pair (MANUAL / FREEZE)
//   step     in   debounced step level (STEP mode)
//   disp1    out  upper display word (registered)
//   disp0    out  lower display word (registered)
//   pairIdx  out  pair being displayed (registered)
//   turnOn   out  2*DIGITS digit enables (registered)
//   frozen   out  high while FREEZE is active (registered)
// -----------------------------------------------------------------------------
module debug_display_ctrl #(
    parameter int  WIDTH     = 16,
    parameter int  NUM_CH    = 8,
    parameter int  DWELL     = 50000000,
    parameter int  BLINK     = 25000000,
    localparam int DIGITS    = WIDTH / 4,
    localparam int NUM_PAIRS = NUM_CH / 2,
    localparam int PW        = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic [NUM_CH*WIDTH-1:0] chData,
    input  logic [1:0]              mode,
    input  logic [PW-1:0]           sel,
    input  logic                    step,
    output logic [WIDTH-1:0]        disp1,
    output logic [WIDTH-1:0]        disp0,
    output logic [PW-1:0]           pairIdx,
    output logic [2*DIGITS-1:0]     turnOn,
    output logic                    frozen
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BCW = (BLINK > 1) ? $clog2(BLINK) : 1;

    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK - 1);
    localparam logic [PW-1:0]  LAST_PAIR  = PW'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    // State
    mode_e                   cur_mode_q, cur_mode_d;
    logic [PW-1:0]           pair_q, pair_d;
    logic [DCW-1:0]          dwell_q, dwell_d;
    logic [BCW-1:0]          blink_q, blink_d;
    logic [2*DIGITS-1:0]     turn_on_q, turn_on_d;
    logic                    frozen_q, frozen_d;
    logic                    step_prev_q, step_prev_d;
    logic [NUM_CH*WIDTH-1:0] snapshot_q, snapshot_d;
    logic [WIDTH-1:0]        disp1_q, disp1_d;
    logic [WIDTH-1:0]        disp0_q, disp0_d;

    // Unpacked views of the live and captured channels
    logic [WIDTH-1:0] live_ch [NUM_CH];
    logic [WIDTH-1:0] snap_ch [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign live_ch[i] = chData[i*WIDTH +: WIDTH];
        assign snap_ch[i] = snapshot_q[i*WIDTH +: WIDTH];
    end

    // Clamp sel into the pair range. When the pair count fills the sel
    // width every encoding is already legal and no compare is needed.
    logic [PW-1:0] sel_clamped;
    if (NUM_PAIRS == (1 << PW)) begin : g_noclamp
        assign sel_clamped = sel;
    end else begin : g_clamp
        assign sel_clamped = (sel > LAST_PAIR) ? LAST_PAIR : sel;
    end

    logic [PW-1:0] pair_inc;
    assign pair_inc = (pair_q == LAST_PAIR) ? '0 : pair_q + 1'b1;

    mode_e mode_in;
    logic  mode_change;
    logic  use_snap;

    assign mode_in     = mode_e'(mode);
    assign mode_change = (mode_in != cur_mode_q);
    // Only a cycle that stays in FREEZE shows the capture; the entry cycle
    // shows live data (identical to what is captured) and the exit cycle
    // already shows live data.
    assign use_snap    = (cur_mode_q == MODE_FREEZE) && !mode_change;

    always_comb begin
        cur_mode_d  = mode_in;
        step_prev_d = step;
        frozen_d    = (mode_in == MODE_FREEZE);
        pair_d      = pair_q;
        dwell_d     = dwell_q;
        blink_d     = blink_q;
        turn_on_d   = turn_on_q;
        snapshot_d  = snapshot_q;

        if (mode_change) begin
            // A mode change only resets timers; it never moves the pair,
            // so a step edge coinciding with it is dropped.
            dwell_d = '0;
            blink_d = '0;
            if (cur_mode_q == MODE_FREEZE) begin
                turn_on_d = '1;
            end
            if (mode_in == MODE_FREEZE) begin
                snapshot_d = chData;
            end
        end else begin
            case (cur_mode_q)
                MODE_MANUAL: begin
                    pair_d = sel_clamped;
                end
                MODE_AUTO: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        pair_d  = pair_inc;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                MODE_STEP: begin
                    if (step && !step_prev_q) begin
                        pair_d = pair_inc;
                    end
                end
                MODE_FREEZE: begin
                    pair_d = sel_clamped;
                    if (blink_q == BLINK_LAST) begin
                        blink_d   = '0;
                        turn_on_d = ~turn_on_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
                default: begin
                    pair_d = pair_q;
                end
            endcase
        end

        // Data follows the next pair so pair and words update together.
        if (use_snap) begin
            disp1_d = snap_ch[{pair_d, 1'b1}];
            disp0_d = snap_ch[{pair_d, 1'b0}];
        end else begin
            disp1_d = live_ch[{pair_d, 1'b1}];
            disp0_d = live_ch[{pair_d, 1'b0}];
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cur_mode_q  <= MODE_MANUAL;
            pair_q      <= '0;
            dwell_q     <= '0;
            blink_q     <= '0;
            turn_on_q   <= '1;
            frozen_q    <= 1'b0;
            step_prev_q <= 1'b0;
            snapshot_q  <= '0;
            disp1_q     <= '0;
            disp0_q     <= '0;
        end else begin
            cur_mode_q  <= cur_mode_d;
            pair_q      <= pair_d;
            dwell_q     <= dwell_d;
            blink_q     <= blink_d;
            turn_on_q   <= turn_on_d;
            frozen_q    <= frozen_d;
            step_prev_q <= step_prev_d;
            snapshot_q  <= snapshot_d;
            disp1_q     <= disp1_d;
            disp0_q     <= disp0_d;
        end
    end

    assign disp1   = disp1_q;
    assign disp0   = disp0_q;
    assign pairIdx = pair_q;
    assign turnOn  = turn_on_q;
    assign frozen  = frozen_q;

endmodule
